// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared BE memory-interface types and helpers.
//   bp_be_fu_op_e          : memory fu_op encoding (bit3 = store, bit2 = unsigned load, bits1:0 = log2 size)
//   bp_be_mem_exception_s  : {load_misaligned, load_access_fault, store_misaligned, store_access_fault}
//   decode_mem_op()        : op -> {valid, store, sign, size}
//   mmu_cmd_width()/mem_resp_width() : flat widths of {mem_op, data, vaddr} and {data, exception, badaddr}
package bp_be_pkg;

    typedef enum logic [3:0] {
        e_lb  = 4'b0000,
        e_lh  = 4'b0001,
        e_lw  = 4'b0010,
        e_ld  = 4'b0011,
        e_lbu = 4'b0100,
        e_lhu = 4'b0101,
        e_lwu = 4'b0110,
        e_sb  = 4'b1000,
        e_sh  = 4'b1001,
        e_sw  = 4'b1010,
        e_sd  = 4'b1011
    } bp_be_fu_op_e;

    typedef struct packed {
        logic load_misaligned;
        logic load_access_fault;
        logic store_misaligned;
        logic store_access_fault;
    } bp_be_mem_exception_s;

    typedef struct packed {
        logic       valid;
        logic       store;
        logic       sign;
        logic [1:0] size;
    } bp_be_mem_size_s;

    localparam int fu_op_width_lp = 4;
    localparam int dword_width_lp = 64;

    function automatic int mmu_cmd_width(input int vaddr_width);
        return fu_op_width_lp + dword_width_lp + vaddr_width;
    endfunction

    function automatic int mem_resp_width(input int vaddr_width);
        return dword_width_lp + $bits(bp_be_mem_exception_s) + vaddr_width;
    endfunction

    function automatic bp_be_mem_size_s decode_mem_op(input logic [3:0] op);
        bp_be_mem_size_s d;
        d.valid = op inside {e_lb, e_lh, e_lw, e_ld, e_lbu, e_lhu, e_lwu, e_sb, e_sh, e_sw, e_sd};
        d.store = op[3];
        d.sign  = ~op[2];
        d.size  = op[1:0];
        return d;
    endfunction

endpackage

// File: rtl/bp_be_dmem_load_align.sv
// bp_be_dmem_load_align: extracts a little-endian sub-word from a 64-bit word and extends it.
//   i_word   : scratchpad word
//   i_offset : byte offset within the word
//   i_op     : fu_op; non-load ops yield zero
//   o_data   : sign/zero-extended 64-bit load data
module bp_be_dmem_load_align
    import bp_be_pkg::*;
(
    input  logic [63:0] i_word,
    input  logic [2:0]  i_offset,
    input  logic [3:0]  i_op,
    output logic [63:0] o_data
);

    bp_be_mem_size_s w_dec;
    logic [63:0]     w_sh;
    logic [63:0]     w_ext;

    always_comb begin
        w_dec  = decode_mem_op(i_op);
        w_sh   = i_word >> {i_offset, 3'b000};
        w_ext  = (w_dec.size == 2'd0) ? {{56{w_dec.sign & w_sh[7]}}, w_sh[7:0]} :
                 (w_dec.size == 2'd1) ? {{48{w_dec.sign & w_sh[15]}}, w_sh[15:0]} :
                 (w_dec.size == 2'd2) ? {{32{w_dec.sign & w_sh[31]}}, w_sh[31:0]} : w_sh;
        o_data = (w_dec.valid & ~w_dec.store) ? w_ext : '0;
    end

endmodule

// File: rtl/bp_be_dmem_responder.sv
// bp_be_dmem_responder: two-stage scratchpad data memory answering BE mmu commands.
//   clk_i, reset_n_i          : clock, synchronous active-low reset
//   mmu_cmd_i/_v_i/_ready_o   : command {mem_op, data, vaddr}, ready-then-valid
//   kill_ex2_i                : squash the command currently in stage A
//   mem_resp_o/_v_o/_ready_i  : response {data, exception, badaddr} with backpressure
module bp_be_dmem_responder
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p             = 22,
    parameter int mem_els_p                 = 512,
    parameter int lce_sets_p                = 64,
    parameter int cce_block_size_in_bytes_p = 64,
    localparam int cmd_width_lp  = mmu_cmd_width(vaddr_width_p),
    localparam int resp_width_lp = mem_resp_width(vaddr_width_p)
)(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [cmd_width_lp-1:0]  mmu_cmd_i,
    input  logic                     mmu_cmd_v_i,
    output logic                     mmu_cmd_ready_o,
    input  logic                     kill_ex2_i,
    output logic [resp_width_lp-1:0] mem_resp_o,
    output logic                     mem_resp_v_o,
    input  logic                     mem_resp_ready_i
);

    localparam int                         addr_w_lp = $clog2(mem_els_p);
    localparam logic [vaddr_width_p-4:0]   els_lp    = (vaddr_width_p-3)'(mem_els_p);
    // Cache-geometry parameters only shape the shared structs upstream; reject nonsense configs.
    localparam logic                       cfg_ok_lp = (lce_sets_p > 0) && (cce_block_size_in_bytes_p >= 8);

    logic [63:0]              r_mem [mem_els_p];
    logic                     r_a_v;
    logic [3:0]               r_a_op;
    logic [63:0]              r_a_data;
    logic [vaddr_width_p-1:0] r_a_vaddr;
    logic                     r_b_v;
    logic [resp_width_lp-1:0] r_resp;

    bp_be_mem_size_s          w_dec;
    bp_be_mem_exception_s     w_exc;
    logic [vaddr_width_p-4:0] w_idx;
    logic [2:0]               w_off;
    logic                     w_mis;
    logic                     w_fault;
    logic                     w_load;
    logic                     w_store;
    logic                     w_any_exc;
    logic [63:0]              w_word;
    logic [63:0]              w_load_data;
    logic [63:0]              w_wdata;
    logic [7:0]               w_mask;
    logic [resp_width_lp-1:0] w_resp;
    logic                     w_stall;
    logic                     w_a_live;
    logic                     w_accept;
    logic                     w_commit;

    assign w_idx  = r_a_vaddr[vaddr_width_p-1:3];
    assign w_off  = r_a_vaddr[2:0];
    assign w_word = r_mem[w_idx[addr_w_lp-1:0]];

    bp_be_dmem_load_align u_align (
        .i_word   (w_word),
        .i_offset (w_off),
        .i_op     (r_a_op),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_dec                    = decode_mem_op(r_a_op);
        w_load                   = w_dec.valid & ~w_dec.store;
        w_store                  = w_dec.valid & w_dec.store;
        // size 3 wraps (1<<3)-1 to 3'b111 in three bits, giving the full dword alignment mask
        w_mis                    = (w_off & ((3'd1 << w_dec.size) - 3'd1)) != 3'd0;
        w_fault                  = w_idx >= els_lp;
        w_exc.load_misaligned    = w_load & w_mis;
        w_exc.load_access_fault  = w_load & ~w_mis & w_fault;
        w_exc.store_misaligned   = w_store & w_mis;
        w_exc.store_access_fault = w_store & ~w_mis & w_fault;
        w_any_exc                = |w_exc;
        w_resp                   = {w_any_exc ? 64'h0 : w_load_data, w_exc, w_any_exc ? r_a_vaddr : '0};
        w_mask                   = ((w_dec.size == 2'd0) ? 8'h01 :
                                    (w_dec.size == 2'd1) ? 8'h03 :
                                    (w_dec.size == 2'd2) ? 8'h0f : 8'hff) << w_off;
        w_wdata                  = r_a_data << {w_off, 3'b000};
        w_stall                  = r_b_v & ~mem_resp_ready_i;
        w_a_live                 = r_a_v & ~kill_ex2_i;
        mmu_cmd_ready_o          = cfg_ok_lp & reset_n_i & ~(w_stall & r_a_v);
        w_accept                 = mmu_cmd_v_i & mmu_cmd_ready_o;
        w_commit                 = reset_n_i & w_a_live & ~w_stall & w_store & ~w_any_exc;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_a_v  <= 1'b0;
            r_b_v  <= 1'b0;
            r_resp <= '0;
        end else begin
            if (w_accept) begin
                r_a_v                         <= 1'b1;
                {r_a_op, r_a_data, r_a_vaddr} <= mmu_cmd_i;
            end else if (!w_stall || kill_ex2_i) begin
                r_a_v <= 1'b0;
            end
            if (!w_stall) begin
                r_b_v <= w_a_live;
                if (w_a_live) r_resp <= w_resp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_commit)
            for (int i = 0; i < 8; i++)
                if (w_mask[i]) r_mem[w_idx[addr_w_lp-1:0]][i*8 +: 8] <= w_wdata[i*8 +: 8];
    end

    assign mem_resp_o   = r_resp;
    assign mem_resp_v_o = r_b_v;

endmodule
